// File: rtl/block_streamer_if.sv
// Platform beat stream between the block streamer (master) and its consumer (slave).
// Valid/ready handshake; payload holds steady while a beat waits for acceptance.
interface block_streamer_if #(
    parameter int PLAT_PER_BLOCK = 7,
    parameter int PHY_WIDTH      = 16,
    parameter int LEN_WIDTH      = 4
);
    localparam int IDX_W = (PLAT_PER_BLOCK > 1) ? $clog2(PLAT_PER_BLOCK) : 1;

    logic                 plat_valid;
    logic                 plat_ready;
    logic [IDX_W-1:0]     plat_idx;
    logic [PHY_WIDTH-1:0] plat_x;
    logic [PHY_WIDTH-1:0] plat_y;
    logic [LEN_WIDTH-1:0] plat_len;
    logic                 plat_last;

    modport master (
        output plat_valid, plat_idx, plat_x, plat_y, plat_len, plat_last,
        input  plat_ready
    );

    modport slave (
        input  plat_valid, plat_idx, plat_x, plat_y, plat_len, plat_last,
        output plat_ready
    );
endinterface

// File: rtl/block_streamer.sv
// Tracks which vertical block the character occupies and streams that block's
// platform list to a consumer, restarting whenever the block changes.
module block_streamer #(
    parameter int BLOCK_NUM      = 7,
    parameter int PLAT_PER_BLOCK = 7,
    parameter int PHY_WIDTH      = 16,
    parameter int CAMERA_WIDTH   = 6,
    parameter int BLOCK_HEIGHT   = 480,
    parameter int LEN_WIDTH      = 4,
    parameter int HYST           = 8
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic signed [PHY_WIDTH:0]   abs_char_y,
    block_streamer_if.master            plat,
    output logic [CAMERA_WIDTH-1:0]     camera_y,
    output logic [3:0]                  cur_block_type,
    output logic                        block_switch,
    output logic                        switch_up
);

    localparam int               IDX_W    = (PLAT_PER_BLOCK > 1) ? $clog2(PLAT_PER_BLOCK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PLAT_PER_BLOCK - 1);
    localparam logic [3:0]       TYPE_MAX = 4'(BLOCK_NUM - 1);
    localparam int               EXT_W    = PHY_WIDTH + 2;

    typedef enum logic [0:0] {S_IDLE, S_STREAM} state_t;

    function automatic logic [PHY_WIDTH-1:0] clamp_y(input logic signed [PHY_WIDTH:0] v);
        return v[PHY_WIDTH] ? '0 : v[PHY_WIDTH-1:0];
    endfunction

    function automatic logic [CAMERA_WIDTH-1:0] sat_cam(input logic [PHY_WIDTH-1:0] cnt);
        if (cnt >= PHY_WIDTH'(2**CAMERA_WIDTH - 1))
            return '1;
        return cnt[CAMERA_WIDTH-1:0];
    endfunction

    function automatic logic [3:0] type_inc(input logic [3:0] t);
        return (t == TYPE_MAX) ? 4'd0 : t + 4'd1;
    endfunction

    function automatic logic [3:0] type_dec(input logic [3:0] t);
        return (t == 4'd0) ? TYPE_MAX : t - 4'd1;
    endfunction

    // Entry packing: {x[8:0], y[8:0], len[3:0]}; key = {type, beat}.
    function automatic logic [21:0] plat_lut(input logic [3:0] t, input logic [IDX_W-1:0] i);
        logic [6:0]  key;
        logic [21:0] ent;
        key = {t, 3'(i)};
        ent = '0;
        case (key)
            7'd0:  ent = {9'd280, 9'd75,  4'd10};
            7'd1:  ent = {9'd100, 9'd100, 4'd8};
            7'd2:  ent = {9'd370, 9'd200, 4'd10};
            7'd3:  ent = {9'd30,  9'd250, 4'd8};
            7'd4:  ent = {9'd250, 9'd320, 4'd8};
            7'd5:  ent = {9'd120, 9'd380, 4'd8};
            7'd6:  ent = {9'd400, 9'd380, 4'd8};
            7'd8:  ent = {9'd300, 9'd30,  4'd10};
            7'd9:  ent = {9'd60,  9'd120, 4'd8};
            7'd10: ent = {9'd220, 9'd160, 4'd6};
            7'd11: ent = {9'd380, 9'd220, 4'd8};
            7'd12: ent = {9'd140, 9'd280, 4'd10};
            7'd13: ent = {9'd20,  9'd360, 4'd6};
            7'd14: ent = {9'd320, 9'd420, 4'd8};
            7'd16: ent = {9'd40,  9'd40,  4'd8};
            7'd17: ent = {9'd200, 9'd90,  4'd10};
            7'd18: ent = {9'd360, 9'd150, 4'd8};
            7'd19: ent = {9'd120, 9'd210, 4'd6};
            7'd20: ent = {9'd280, 9'd270, 4'd8};
            7'd21: ent = {9'd420, 9'd330, 4'd6};
            7'd22: ent = {9'd180, 9'd400, 4'd10};
            7'd24: ent = {9'd350, 9'd50,  4'd8};
            7'd25: ent = {9'd150, 9'd110, 4'd6};
            7'd26: ent = {9'd10,  9'd170, 4'd10};
            7'd27: ent = {9'd250, 9'd230, 4'd8};
            7'd28: ent = {9'd400, 9'd290, 4'd8};
            7'd29: ent = {9'd90,  9'd350, 4'd10};
            7'd30: ent = {9'd260, 9'd430, 4'd6};
            7'd32: ent = {9'd100, 9'd20,  4'd12};
            7'd33: ent = {9'd300, 9'd80,  4'd6};
            7'd34: ent = {9'd180, 9'd140, 4'd8};
            7'd35: ent = {9'd40,  9'd200, 4'd10};
            7'd36: ent = {9'd340, 9'd260, 4'd6};
            7'd37: ent = {9'd200, 9'd330, 4'd8};
            7'd38: ent = {9'd60,  9'd410, 4'd12};
            7'd40: ent = {9'd220, 9'd60,  4'd6};
            7'd41: ent = {9'd420, 9'd110, 4'd8};
            7'd42: ent = {9'd80,  9'd180, 4'd8};
            7'd43: ent = {9'd260, 9'd240, 4'd10};
            7'd44: ent = {9'd10,  9'd300, 4'd6};
            7'd45: ent = {9'd330, 9'd360, 4'd8};
            7'd46: ent = {9'd150, 9'd440, 4'd10};
            7'd48: ent = {9'd160, 9'd35,  4'd10};
            7'd49: ent = {9'd20,  9'd95,  4'd6};
            7'd50: ent = {9'd300, 9'd155, 4'd8};
            7'd51: ent = {9'd440, 9'd215, 4'd6};
            7'd52: ent = {9'd190, 9'd285, 4'd10};
            7'd53: ent = {9'd50,  9'd345, 4'd8};
            7'd54: ent = {9'd380, 9'd415, 4'd8};
            default: ent = '0;
        endcase
        return ent;
    endfunction

    logic [PHY_WIDTH-1:0] y_q;
    logic [PHY_WIDTH-1:0] base;
    logic [PHY_WIDTH-1:0] blk_cnt;
    logic [3:0]           type_q;
    logic [PHY_WIDTH:0]   up_thresh;
    logic [EXT_W-1:0]     up_top;
    logic                 step_up;
    logic                 step_dn;

    state_t               state_q;
    state_t               state_nxt;
    logic                 pending;
    logic                 pend_clr;
    logic                 vld_p2;
    logic                 vld_nxt;
    logic [IDX_W-1:0]     idx_p2;
    logic [IDX_W-1:0]     idx_nxt;
    logic [3:0]           ltype_p2;
    logic [3:0]           ltype_nxt;
    logic [21:0]          lut_ent;
    logic [PHY_WIDTH-1:0] px_p2;
    logic [PHY_WIDTH-1:0] py_p2;
    logic [LEN_WIDTH-1:0] plen_p2;

    // Stage p0: register and clamp the character height.
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            y_q <= '0;
        else
            y_q <= clamp_y(abs_char_y);
    end

    // Stage p1: block step decision. Compares run one bit wider so base+height cannot wrap.
    always_comb begin
        up_thresh = {1'b0, base} + (PHY_WIDTH+1)'(BLOCK_HEIGHT);
        up_top    = EXT_W'(base) + EXT_W'(2 * BLOCK_HEIGHT);
        step_up   = ({1'b0, y_q} >= up_thresh) && (up_top <= EXT_W'(2**PHY_WIDTH - 1));
        step_dn   = !step_up && (base != '0)
                    && (({1'b0, y_q} + (PHY_WIDTH+1)'(HYST)) < {1'b0, base});
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            base         <= '0;
            blk_cnt      <= '0;
            type_q       <= '0;
            camera_y     <= '0;
            block_switch <= 1'b0;
            switch_up    <= 1'b0;
        end else begin
            block_switch <= step_up | step_dn;
            switch_up    <= step_up;
            if (step_up) begin
                base     <= base + PHY_WIDTH'(BLOCK_HEIGHT);
                blk_cnt  <= blk_cnt + PHY_WIDTH'(1);
                type_q   <= type_inc(type_q);
                camera_y <= sat_cam(blk_cnt + PHY_WIDTH'(1));
            end else if (step_dn) begin
                base     <= base - PHY_WIDTH'(BLOCK_HEIGHT);
                blk_cnt  <= blk_cnt - PHY_WIDTH'(1);
                type_q   <= type_dec(type_q);
                camera_y <= sat_cam(blk_cnt - PHY_WIDTH'(1));
            end
        end
    end

    // Stage p2: stream FSM. A pending switch aborts the current list at the next handshake.
    always_comb begin
        state_nxt = state_q;
        vld_nxt   = vld_p2;
        idx_nxt   = idx_p2;
        ltype_nxt = ltype_p2;
        pend_clr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending) begin
                    state_nxt = S_STREAM;
                    vld_nxt   = 1'b1;
                    idx_nxt   = '0;
                    ltype_nxt = type_q;
                    pend_clr  = 1'b1;
                end
            end
            S_STREAM: begin
                if (vld_p2 && plat.plat_ready) begin
                    if (pending) begin
                        idx_nxt   = '0;
                        ltype_nxt = type_q;
                        pend_clr  = 1'b1;
                    end else if (idx_p2 == LAST_IDX) begin
                        state_nxt = S_IDLE;
                        vld_nxt   = 1'b0;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx_p2 + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                vld_nxt   = 1'b0;
                idx_nxt   = '0;
            end
        endcase
        lut_ent = plat_lut(ltype_nxt, idx_nxt);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            pending  <= 1'b1;
            vld_p2   <= 1'b0;
            idx_p2   <= '0;
            ltype_p2 <= '0;
        end else begin
            state_q  <= state_nxt;
            pending  <= step_up | step_dn | (pending & ~pend_clr);
            vld_p2   <= vld_nxt;
            idx_p2   <= idx_nxt;
            ltype_p2 <= ltype_nxt;
        end
    end

    // Payload follows the next-cycle index, so it is ready when valid rises and frozen on stall.
    always_ff @(posedge sys_clk) begin
        px_p2   <= PHY_WIDTH'(lut_ent[21:13]);
        py_p2   <= PHY_WIDTH'(lut_ent[12:4]);
        plen_p2 <= LEN_WIDTH'(lut_ent[3:0]);
    end

    assign plat.plat_valid = vld_p2;
    assign plat.plat_idx   = idx_p2;
    assign plat.plat_x     = px_p2;
    assign plat.plat_y     = py_p2;
    assign plat.plat_len   = plen_p2;
    assign plat.plat_last  = vld_p2 && (idx_p2 == LAST_IDX);
    assign cur_block_type  = type_q;

endmodule
